exu_wb_merge: RTL
=================

# exu_wb_merge

Write-back merge stage between the execution units and the register file. It takes the single-port result stream from the ALU/LSU path and the result stream from the 4-stage `mac` unit, and funnels both into the one register-file write port. The ALU path always has priority. MAC results that cannot write immediately are held in a small in-order FIFO. Every buffered destination is exported as a pending-register mask so decode can interlock readers.

## Interface
Parameters:
- XLEN, 32, datapath width
- DEPTH, 2, MAC result FIFO entries; power of two, ≥2

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- freeze  in  1  global pipeline stall; no state update while high
- alu_out  in  XLEN  ALU/LSU result data
- alu_rd_addr  in  5  ALU destination
- alu_rd_wr_en  in  1  ALU write request
- alu_instr_tag  in  XLEN  ALU instruction tag
- mac_out  in  XLEN  MAC result data
- mac_rd_addr  in  5  MAC destination
- mac_rd_wr_en  in  1  MAC write request
- mac_instr_tag  in  XLEN  MAC instruction tag
- wb_data  out  XLEN  register-file write data
- wb_rd_addr  out  5  register-file write address
- wb_wr_en  out  1  register-file write strobe
- wb_instr_tag  out  XLEN  tag of the retiring write
- pending_rd_mask  out  32  one-hot OR of destinations held in valid FIFO entries; bit 0 always 0
- mac_wb_full  out  1  FIFO holds DEPTH entries; upstream ORs this into freeze
- mac_wb_overflow  out  1  sticky error: a MAC push was lost

## Operation
- ALU claim: `alu_rd_wr_en && alu_rd_addr != 0`. A claim drives wb_* straight from the alu_* inputs.
- Pop: no ALU claim, freeze low, FIFO non-empty → pop the head.
  - Head valid → wb_* = head entry, wb_wr_en = 1.
  - Head squashed → wb_wr_en = 0.
- Push: freeze low and `mac_rd_wr_en` and `mac_rd_addr != 0` → enqueue {data, rd, tag, valid=1} at the tail. A push is suppressed when:
  - the ALU claims the same rd in that cycle (the MAC result is older, so the ALU write supersedes it), or
  - the bypass path takes it (see Configuration).
- Squash: on every ALU claim with freeze low, each valid FIFO entry whose rd equals alu_rd_addr has its valid bit cleared. It keeps its slot and count, and is dropped when it reaches the head.
- Simultaneous push and pop: both happen and count is unchanged. A push to a full FIFO with a same-cycle pop is legal.
- Push while full without a pop: the new entry is discarded, mac_wb_overflow is set, and the FIFO is unchanged.
- Writes to x0 are never buffered and never written.
- freeze high:
  - pointers, count, valid bits and the overflow flag hold;
  - wb_wr_en = 0;
  - wb_data, wb_rd_addr and wb_instr_tag still show the would-be selection.
- Ordering: retirement is in FIFO order among MAC results. The ALU result may retire ahead of buffered MAC results only for a different rd; squash guarantees this.

## Timing
- Reset values: FIFO empty, count 0, all valid bits 0, pending_rd_mask 0, mac_wb_full 0, mac_wb_overflow 0, wb_wr_en 0, wb_data/wb_rd_addr/wb_instr_tag 0.
- wb_* are combinational from the alu_* inputs and the FIFO head. No register sits between the ALU claim and wb_wr_en.
- MAC latency:
  - 1 cycle minimum through the FIFO: push at edge N, write in cycle N+1;
  - 0 cycles when bypass applies;
  - each cycle of ALU claim adds one cycle of delay.
- pending_rd_mask and mac_wb_full are derived from registered FIFO state and update the cycle after a push, pop or squash edge.
- Reset asserted mid-operation drops all buffered entries immediately (asynchronous). wb_wr_en falls without waiting for a clock edge.
- Pointers wrap modulo DEPTH. Count spans 0..DEPTH.

## Configuration
- Macro: `EXU_WB_MAC_BYPASS_EN`.
- Defined: when the FIFO is empty, there is no ALU claim and freeze is low, a MAC write request retires in the same cycle on wb_* and is not pushed.
- Undefined: every MAC result goes through the FIFO, so MAC-to-regfile latency is at least 1 cycle and wb_* are never combinational from mac_* inputs.

## Test plan
- Lone MAC write, rd=5, data=0x0000_0042, idle ALU:
  - bypass on → wb_wr_en=1 that cycle with rd=5, data=0x42;
  - bypass off → write one cycle later;
  - bit 5 of pending_rd_mask high for exactly 1 cycle (bypass off only).
- ALU claims rd=3 for 3 consecutive cycles while MAC pushes rd=7 and rd=8 → mac_wb_full=1 (DEPTH=2); then rd=7 retires, then rd=8, on consecutive free cycles.
- MAC rd=9 buffered, then an ALU claim of rd=9 with 0x1111 → entry squashed, bit 9 of the mask clears, final x9=0x1111, and no later write to x9.
- Same-cycle MAC rd=4 (0xAAAA) and ALU claim rd=4 (0xBBBB) → single write 0xBBBB, nothing pushed.
- FIFO full, ALU claims, MAC pushes rd=12 → mac_wb_overflow=1 and stays set; FIFO contents unchanged.
- MAC rd=0 writes are ignored.
- freeze held 4 cycles with 2 entries buffered → wb_wr_en=0 throughout, count stays 2, then normal draining.
- rst_n pulsed with 2 entries buffered → all outputs return to their reset values.

Source files
------------

// File: rtl/exu_wb_merge.sv
// exu_wb_merge: write-back merge of the ALU/LSU result stream and the MAC
// result stream into the single register-file write port. The ALU path has
// priority. MAC results wait in a small in-order FIFO, and their destinations
// are exported as a pending mask so that decode can interlock readers.
// Optional feature macro: EXU_WB_MAC_BYPASS_EN. When it is defined, a MAC
// result retires in the same cycle if the FIFO is empty and the port is free.
module exu_wb_merge #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            freeze,
  input  logic [XLEN-1:0] alu_out,
  input  logic [4:0]      alu_rd_addr,
  input  logic            alu_rd_wr_en,
  input  logic [XLEN-1:0] alu_instr_tag,
  input  logic [XLEN-1:0] mac_out,
  input  logic [4:0]      mac_rd_addr,
  input  logic            mac_rd_wr_en,
  input  logic [XLEN-1:0] mac_instr_tag,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd_addr,
  output logic            wb_wr_en,
  output logic [XLEN-1:0] wb_instr_tag,
  output logic [31:0]     pending_rd_mask,
  output logic            mac_wb_full,
  output logic            mac_wb_overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic [XLEN-1:0] tag;
  } ent_t;

  ent_t             r_ent [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic        w_alu_claim;
  logic        w_mac_req;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_bypass;
  logic        w_push_req;
  logic        w_push;
  logic        w_ovf_set;
  logic [31:0] w_mask;

  // Arbitration between the ALU claim, FIFO pop, MAC push and bypass
  assign w_alu_claim = alu_rd_wr_en && (alu_rd_addr != 5'd0);
  assign w_mac_req   = mac_rd_wr_en && (mac_rd_addr != 5'd0);
  assign w_empty     = (r_count == CNT_W'(0));
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_pop       = !w_alu_claim && !freeze && !w_empty;

`ifdef EXU_WB_MAC_BYPASS_EN
  assign w_bypass    = w_mac_req && w_empty && !w_alu_claim && !freeze;
`else
  assign w_bypass    = 1'b0;
`endif

  // A same-rd ALU claim supersedes the older MAC result, so it is never queued
  assign w_push_req  = !freeze && w_mac_req && !w_bypass &&
                       !(w_alu_claim && (alu_rd_addr == mac_rd_addr));
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_ovf_set   = w_push_req && w_full && !w_pop;

  // FIFO storage, pointers, squash and the sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_ent[i] <= '0;
      end
      r_valid    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (!freeze) begin
      if (w_alu_claim) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (r_ent[i].rd == alu_rd_addr) begin
            r_valid[i] <= 1'b0;
          end
        end
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      // Placed after the pop so a full-FIFO push into the freed slot wins
      if (w_push) begin
        r_ent[r_tail]   <= '{data: mac_out, rd: mac_rd_addr, tag: mac_instr_tag};
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Pending-destination mask over valid entries; popped slots are cleared
  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_valid[i]) begin
        w_mask[r_ent[i].rd] = 1'b1;
      end
    end
    w_mask[0] = 1'b0;
  end

  assign pending_rd_mask = w_mask;
  assign mac_wb_full     = w_full;
  assign mac_wb_overflow = r_overflow;

  // Write-port mux; forced idle while reset is asserted
  always_comb begin
    wb_wr_en     = 1'b0;
    wb_data      = '0;
    wb_rd_addr   = '0;
    wb_instr_tag = '0;
    if (rst_n) begin
      if (w_alu_claim) begin
        wb_data      = alu_out;
        wb_rd_addr   = alu_rd_addr;
        wb_instr_tag = alu_instr_tag;
        wb_wr_en     = !freeze;
      end
`ifdef EXU_WB_MAC_BYPASS_EN
      else if (w_bypass) begin
        wb_data      = mac_out;
        wb_rd_addr   = mac_rd_addr;
        wb_instr_tag = mac_instr_tag;
        wb_wr_en     = 1'b1;
      end
`endif
      else if (!w_empty) begin
        wb_data      = r_ent[r_head].data;
        wb_rd_addr   = r_ent[r_head].rd;
        wb_instr_tag = r_ent[r_head].tag;
        wb_wr_en     = !freeze && r_valid[r_head];
      end
    end
  end

endmodule
